// File: rtl/mnist_image_feeder_if.sv
// Host/core-facing signal bundle for mnist_image_feeder.
// The master modport is the environment (host bus logic plus the core's
// result side). The slave modport is the feeder itself.
interface mnist_image_feeder_if #(
    parameter int DATA_WIDTH   = 24,
    parameter int IMAGE_PIXELS = 784
);
    localparam int AW = $clog2(IMAGE_PIXELS);

    // Host pixel write port
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [7:0]            wr_data;

    // Host control and result
    logic                  start;
    logic                  busy;
    logic                  result_valid;
    logic [3:0]            result_digit;
    logic                  timeout;
    logic                  result_ack;

    // Core serial pixel port
    logic                  core_rst;
    logic                  core_valid;
    logic [DATA_WIDTH-1:0] core_pixel;
    logic                  core_o_valid;
    logic [3:0]            core_digit;

    modport master (
        output wr_en, wr_addr, wr_data, start, result_ack,
        output core_o_valid, core_digit,
        input  busy, result_valid, result_digit, timeout,
        input  core_rst, core_valid, core_pixel
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, result_ack,
        input  core_o_valid, core_digit,
        output busy, result_valid, result_digit, timeout,
        output core_rst, core_valid, core_pixel
    );
endinterface

// File: rtl/mnist_image_feeder.sv
// mnist_image_feeder: buffers one grayscale image from the host, resets the
// MNIST core, streams the image as fixed-point pixels (pixel/256), then waits
// for the predicted digit or a timeout and holds the result until acknowledged.
// Legal parameters: FRAC_BITS >= 8, DATA_WIDTH >= FRAC_BITS+1, TIMEOUT >= 2.
module mnist_image_feeder #(
    parameter int DATA_WIDTH   = 24,
    parameter int FRAC_BITS    = 16,
    parameter int IMAGE_PIXELS = 784,
    parameter int TIMEOUT      = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    mnist_image_feeder_if.slave   fd
);
    localparam int AW = $clog2(IMAGE_PIXELS);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] LAST_PIX = AW'(IMAGE_PIXELS - 1);
    localparam logic [TW-1:0] LAST_TO  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_PRIME  = 3'd2,
        S_STREAM = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Unsigned 8-bit grayscale to core fixed point (value/256).
    function automatic logic [DATA_WIDTH-1:0] to_fixed(input logic [7:0] pix);
        logic [DATA_WIDTH-1:0] wide;
        wide = DATA_WIDTH'(pix);
        return wide << (FRAC_BITS - 8);
    endfunction

    // Saturating read-address increment; the last pixel address is held so the
    // RAM is never addressed past its end while the tail of the image drains.
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        if (a == LAST_PIX) begin
            r = a;
        end else begin
            r = a + AW'(1);
        end
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [AW-1:0]         rd_addr_q, rd_addr_d;
    logic [AW-1:0]         pix_cnt_q, pix_cnt_d;
    logic [TW-1:0]         to_cnt_q, to_cnt_d;
    logic                  busy_q, busy_d;
    logic                  core_valid_q, core_valid_d;
    logic [DATA_WIDTH-1:0] core_pixel_q, core_pixel_d;
    logic                  result_valid_q, result_valid_d;
    logic [3:0]            result_digit_q, result_digit_d;
    logic                  timeout_q, timeout_d;

    logic [7:0]            mem_q [IMAGE_PIXELS];
    logic [7:0]            rd_data_q;
    logic                  addr_ok_s;
    logic                  wr_ok_s;
    logic [AW-1:0]         ram_addr_s;

    // Host writes are accepted only while idle/done and in range.
    always_comb begin
        addr_ok_s = ({1'b0, fd.wr_addr} < (AW+1)'(IMAGE_PIXELS));
        wr_ok_s   = fd.wr_en && !busy_q && addr_ok_s;
        // Single RAM port: the sequencer owns it while busy, the host otherwise.
        if (busy_q) begin
            ram_addr_s = rd_addr_q;
        end else if (addr_ok_s) begin
            ram_addr_s = fd.wr_addr;
        end else begin
            ram_addr_s = '0;
        end
    end

    // Image buffer: single-port RAM with synchronous read, contents not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[ram_addr_s] <= fd.wr_data;
        end
        rd_data_q <= mem_q[ram_addr_s];
    end

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d        = state_q;
        rd_addr_d      = rd_addr_q;
        pix_cnt_d      = pix_cnt_q;
        to_cnt_d       = to_cnt_q;
        result_valid_d = result_valid_q;
        result_digit_d = result_digit_q;
        timeout_d      = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (fd.start) begin
                    state_d   = S_CLEAR;
                    rd_addr_d = '0;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_CLEAR: begin
                // Address 0 is read at the end of this cycle.
                state_d   = S_PRIME;
                rd_addr_d = addr_inc(rd_addr_q);
                pix_cnt_d = '0;
            end
            S_PRIME: begin
                state_d   = S_STREAM;
                rd_addr_d = addr_inc(rd_addr_q);
            end
            S_STREAM: begin
                if (pix_cnt_q == LAST_PIX) begin
                    state_d  = S_WAIT;
                    to_cnt_d = '0;
                end else begin
                    pix_cnt_d = pix_cnt_q + AW'(1);
                    rd_addr_d = addr_inc(rd_addr_q);
                end
            end
            S_WAIT: begin
                if (fd.core_o_valid) begin
                    state_d        = S_DONE;
                    result_valid_d = 1'b1;
                    result_digit_d = fd.core_digit;
                    timeout_d      = 1'b0;
                end else if (to_cnt_q == LAST_TO) begin
                    state_d        = S_DONE;
                    result_valid_d = 1'b1;
                    result_digit_d = 4'hF;
                    timeout_d      = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                // A new start wins over a simultaneous acknowledge.
                if (fd.start) begin
                    state_d        = S_CLEAR;
                    rd_addr_d      = '0;
                    result_valid_d = 1'b0;
                end else if (fd.result_ack) begin
                    state_d        = S_IDLE;
                    result_valid_d = 1'b0;
                end else begin
                    state_d        = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d       = (state_d == S_CLEAR) || (state_d == S_PRIME) ||
                       (state_d == S_STREAM) || (state_d == S_WAIT);
        core_valid_d = (state_d == S_STREAM);
        if (core_valid_d) begin
            core_pixel_d = to_fixed(rd_data_q);
        end else begin
            core_pixel_d = '0;
        end
    end

    // State, counters and registered outputs; reset aborts any image in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            rd_addr_q      <= '0;
            pix_cnt_q      <= '0;
            to_cnt_q       <= '0;
            busy_q         <= 1'b0;
            core_valid_q   <= 1'b0;
            core_pixel_q   <= '0;
            result_valid_q <= 1'b0;
            result_digit_q <= 4'h0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_addr_q      <= rd_addr_d;
            pix_cnt_q      <= pix_cnt_d;
            to_cnt_q       <= to_cnt_d;
            busy_q         <= busy_d;
            core_valid_q   <= core_valid_d;
            core_pixel_q   <= core_pixel_d;
            result_valid_q <= result_valid_d;
            result_digit_q <= result_digit_d;
            timeout_q      <= timeout_d;
        end
    end

    // The core is held in reset whenever the feeder is, and pulsed in CLEAR.
    assign fd.core_rst     = rst | (state_q == S_CLEAR);
    assign fd.busy         = busy_q;
    assign fd.core_valid   = core_valid_q;
    assign fd.core_pixel   = core_pixel_q;
    assign fd.result_valid = result_valid_q;
    assign fd.result_digit = result_digit_q;
    assign fd.timeout      = timeout_q;
endmodule

// File: tb/tb_mnist_image_feeder.sv
// Directed self-checking bench for mnist_image_feeder (TIMEOUT=16).
module tb_mnist_image_feeder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n;
    int   cnt;
    logic [23:0] cap [0:999];

    mnist_image_feeder_if #(.DATA_WIDTH(24), .IMAGE_PIXELS(784)) bus ();

    mnist_image_feeder #(
        .DATA_WIDTH(24), .FRAC_BITS(16), .IMAGE_PIXELS(784), .TIMEOUT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fd  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start (optionally with ack) and check the CLEAR and PRIME cycles.
    task automatic start_image(input logic with_ack);
        bus.start = 1'b1;
        bus.result_ack = with_ack;
        tick();
        bus.start = 1'b0;
        bus.result_ack = 1'b0;
        chk("clear_core_rst", 32'(bus.core_rst), 32'd1);
        chk("clear_busy", 32'(bus.busy), 32'd1);
        chk("clear_valid", 32'(bus.core_valid), 32'd0);
        chk("clear_result_valid", 32'(bus.result_valid), 32'd0);
        tick();
        chk("prime_core_rst", 32'(bus.core_rst), 32'd0);
        chk("prime_valid", 32'(bus.core_valid), 32'd0);
        tick();
    endtask

    // Capture consecutive valid pixels; optionally inject a protected write and
    // start at pixel inj_at, and a stale core_o_valid (digit 3) at stale_at.
    task automatic run_stream(input int inj_at, input int stale_at, output int cnt_o);
        cnt_o = 0;
        while (bus.core_valid === 1'b1 && cnt_o < 1000) begin
            cap[cnt_o] = bus.core_pixel;
            bus.wr_en        = (cnt_o == inj_at);
            bus.start        = (cnt_o == inj_at);
            bus.wr_addr      = 10'd5;
            bus.wr_data      = 8'hAA;
            bus.core_o_valid = (cnt_o == stale_at);
            bus.core_digit   = 4'd3;
            cnt_o++;
            tick();
        end
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        bus.core_o_valid = 1'b0;
    endtask

    // At WAIT entry: wait dly cycles, then return a digit from the core.
    task automatic finish_wait(input logic [3:0] digit, input int dly);
        chk("wait_busy", 32'(bus.busy), 32'd1);
        chk("wait_valid", 32'(bus.core_valid), 32'd0);
        repeat (dly) tick();
        chk("wait_no_result", 32'(bus.result_valid), 32'd0);
        bus.core_o_valid = 1'b1;
        bus.core_digit = digit;
        tick();
        bus.core_o_valid = 1'b0;
        chk("done_result_valid", 32'(bus.result_valid), 32'd1);
        chk("done_digit", 32'(bus.result_digit), 32'(digit));
        chk("done_timeout", 32'(bus.timeout), 32'd0);
        chk("done_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic ack_result();
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        chk("ack_result_valid", 32'(bus.result_valid), 32'd0);
        chk("ack_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        n_checks = 0;
        n_fail = 0;
        bus.wr_en = 1'b0;
        bus.wr_addr = 10'd0;
        bus.wr_data = 8'd0;
        bus.start = 1'b0;
        bus.result_ack = 1'b0;
        bus.core_o_valid = 1'b0;
        bus.core_digit = 4'd0;

        // Reset state
        repeat (2) tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_core_valid", 32'(bus.core_valid), 32'd0);
        chk("rst_core_pixel", 32'(bus.core_pixel), 32'd0);
        chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_result_digit", 32'(bus.result_digit), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_core_rst", 32'(bus.core_rst), 32'd1);
        rst = 1'b0;
        tick();
        chk("idle_core_rst", 32'(bus.core_rst), 32'd0);

        // Load pixel[i] = i mod 256, then an out-of-range write that must drop
        for (int i = 0; i < 784; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_addr = 10'(i);
            bus.wr_data = 8'(i);
            tick();
        end
        bus.wr_addr = 10'd800;
        bus.wr_data = 8'h55;
        tick();
        bus.wr_en = 1'b0;

        // Basic classification
        start_image(1'b0);
        run_stream(-1, -1, n);
        chk("basic_len", 32'(n), 32'd784);
        chk("basic_pix0", 32'(cap[0]), 32'h000000);
        chk("basic_pix5", 32'(cap[5]), 32'h000500);
        chk("basic_pix128", 32'(cap[128]), 32'h008000);
        chk("basic_pix255", 32'(cap[255]), 32'h00FF00);
        chk("basic_pix256", 32'(cap[256]), 32'h000000);
        finish_wait(4'd7, 9);
        ack_result();

        // Timeout: WAIT never answered
        start_image(1'b0);
        run_stream(-1, -1, n);
        chk("to_len", 32'(n), 32'd784);
        cnt = 0;
        while (bus.result_valid !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("to_latency", 32'(cnt), 32'd16);
        chk("to_flag", 32'(bus.timeout), 32'd1);
        chk("to_digit", 32'(bus.result_digit), 32'hF);
        chk("to_busy", 32'(bus.busy), 32'd0);
        ack_result();

        // Protection + stale core_o_valid during STREAM
        start_image(1'b0);
        run_stream(2, 300, n);
        chk("prot_len", 32'(n), 32'd784);
        chk("prot_pix5", 32'(cap[5]), 32'h000500);
        chk("prot_pix255", 32'(cap[255]), 32'h00FF00);
        finish_wait(4'd9, 3);

        // Handshake: ack and start together in DONE, then a normal image
        start_image(1'b1);
        run_stream(-1, -1, n);
        chk("hs_len", 32'(n), 32'd784);
        chk("hs_pix5", 32'(cap[5]), 32'h000500);
        chk("hs_pix783", 32'(cap[783]), 32'h000F00);
        finish_wait(4'd2, 0);
        ack_result();

        // Async reset at pixel 400, between clock edges
        start_image(1'b0);
        n = 0;
        while (bus.core_valid === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk("ar_pix400", 32'(bus.core_pixel), 32'h009000);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_core_valid", 32'(bus.core_valid), 32'd0);
        chk("ar_core_rst", 32'(bus.core_rst), 32'd1);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_core_pixel", 32'(bus.core_pixel), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("ar_idle_busy", 32'(bus.busy), 32'd0);
        chk("ar_idle_result", 32'(bus.result_valid), 32'd0);
        chk("ar_idle_valid", 32'(bus.core_valid), 32'd0);
        start_image(1'b0);
        run_stream(-1, -1, n);
        chk("ar_len", 32'(n), 32'd784);
        chk("ar_pix0", 32'(cap[0]), 32'h000000);
        chk("ar_pix400b", 32'(cap[400]), 32'h009000);
        finish_wait(4'd5, 4);
        ack_result();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
